// File: rtl/coreriscv_axi4_network_endpoint_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coreriscv_axi4_network_endpoint_pkg
//  Description : Shared field widths, message layouts and transmit-buffer
//                state encodings for the CoreRISCV AXI4 network endpoint.
//  Revision    : 1.0 - initial release
// ============================================================================
package coreriscv_axi4_network_endpoint_pkg;

    localparam int ID_W     = 2;
    localparam int ADDR_W   = 26;
    localparam int PTYPE_W  = 2;
    localparam int RX_MSG_W = ID_W + ADDR_W + PTYPE_W;

    // Transmit skid-buffer occupancy
    typedef enum logic [1:0] {
        TX_EMPTY = 2'd0,
        TX_ONE   = 2'd1,
        TX_TWO   = 2'd2
    } tx_state_t;

    // One receive-queue entry: where it came from plus the payload
    typedef struct packed {
        logic [ID_W-1:0]    src;
        logic [ADDR_W-1:0]  addr_block;
        logic [PTYPE_W-1:0] p_type;
    } rx_msg_t;

    // One transmit-buffer entry; the source is always this endpoint
    typedef struct packed {
        logic [ID_W-1:0]    dst;
        logic [ADDR_W-1:0]  addr_block;
        logic [PTYPE_W-1:0] p_type;
    } tx_msg_t;

endpackage
`default_nettype wire

// File: rtl/coreriscv_axi4_endpoint_queue.sv
`default_nettype none
// ============================================================================
//  Module      : coreriscv_axi4_endpoint_queue
//  Description : Registered-flag FIFO (no fall-through). enq_ready and
//                deq_valid are registered from the next occupancy, so a pop
//                from full re-opens enq_ready only on the following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module coreriscv_axi4_endpoint_queue #(
    parameter int DEPTH = 4,   // 2, 4 or 8
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active low
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    assign push     = enq_valid && enq_ready;
    assign pop      = deq_valid && deq_ready;
    assign deq_data = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop cancel out
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and the registered handshake flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            enq_ready <= 1'b0;
            deq_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_next;
            enq_ready <= (count_next != FULL_COUNT);
            deq_valid <= (count_next != '0);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enq_data;
    end

endmodule
`default_nettype wire

// File: rtl/coreriscv_axi4_network_endpoint.sv
`default_nettype none
// ============================================================================
//  Module      : coreriscv_axi4_network_endpoint
//  Description : Network endpoint. Receive side filters delivered messages by
//                destination into a FIFO and flags misroutes; transmit side is
//                a two-entry skid buffer stamping this endpoint as source.
//  Revision    : 1.0 - initial release
// ============================================================================
module coreriscv_axi4_network_endpoint
    import coreriscv_axi4_network_endpoint_pkg::*;
#(
    parameter int PORT_ID  = 0,
    parameter int RX_DEPTH = 4    // 2, 4 or 8
) (
    input  logic               clk,
    input  logic               reset,   // asynchronous, active low

    input  logic               io_net_in_valid,
    output logic               io_net_in_ready,
    input  logic [ID_W-1:0]    io_net_in_bits_header_src,
    input  logic [ID_W-1:0]    io_net_in_bits_header_dst,
    input  logic [ADDR_W-1:0]  io_net_in_bits_payload_addr_block,
    input  logic [PTYPE_W-1:0] io_net_in_bits_payload_p_type,

    output logic               io_rx_valid,
    input  logic               io_rx_ready,
    output logic [ID_W-1:0]    io_rx_bits_src,
    output logic [ADDR_W-1:0]  io_rx_bits_addr_block,
    output logic [PTYPE_W-1:0] io_rx_bits_p_type,

    input  logic               io_tx_valid,
    output logic               io_tx_ready,
    input  logic [ID_W-1:0]    io_tx_bits_dst,
    input  logic [ADDR_W-1:0]  io_tx_bits_addr_block,
    input  logic [PTYPE_W-1:0] io_tx_bits_p_type,

    output logic               io_net_out_valid,
    input  logic               io_net_out_ready,
    output logic [ID_W-1:0]    io_net_out_bits_header_src,
    output logic [ID_W-1:0]    io_net_out_bits_header_dst,
    output logic [ADDR_W-1:0]  io_net_out_bits_payload_addr_block,
    output logic [PTYPE_W-1:0] io_net_out_bits_payload_p_type,

    output logic               io_misroute,
    input  logic               io_misroute_clr
);
    localparam logic [ID_W-1:0] MY_ID = ID_W'(PORT_ID);

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    rx_msg_t rx_in;
    rx_msg_t rx_out;
    logic    for_me;
    logic    rx_enq_ready;
    logic    mis_accept;

    assign for_me = (io_net_in_bits_header_dst == MY_ID);
    assign rx_in  = '{src:        io_net_in_bits_header_src,
                      addr_block: io_net_in_bits_payload_addr_block,
                      p_type:     io_net_in_bits_payload_p_type};

    // Misrouted messages are still gated by the FIFO's ready, so a full
    // queue back-pressures every delivery regardless of destination.
    assign io_net_in_ready = rx_enq_ready;
    assign mis_accept      = io_net_in_valid && rx_enq_ready && !for_me;

    coreriscv_axi4_endpoint_queue #(
        .DEPTH (RX_DEPTH),
        .WIDTH (RX_MSG_W)
    ) u_rx_queue (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (io_net_in_valid && for_me),
        .enq_ready (rx_enq_ready),
        .enq_data  (rx_in),
        .deq_valid (io_rx_valid),
        .deq_ready (io_rx_ready),
        .deq_data  (rx_out)
    );

    assign io_rx_bits_src        = rx_out.src;
    assign io_rx_bits_addr_block = rx_out.addr_block;
    assign io_rx_bits_p_type     = rx_out.p_type;

    // Sticky misroute flag; a new misroute beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_misroute <= 1'b0;
        end else if (mis_accept) begin
            io_misroute <= 1'b1;
        end else if (io_misroute_clr) begin
            io_misroute <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    tx_state_t tx_state;
    tx_msg_t   tx_in;
    tx_msg_t   head;    // oldest entry, drives the bus
    tx_msg_t   tail;    // second entry, only meaningful in TX_TWO
    logic      tx_push;
    logic      tx_pop;

    assign tx_in   = '{dst:        io_tx_bits_dst,
                       addr_block: io_tx_bits_addr_block,
                       p_type:     io_tx_bits_p_type};
    assign tx_push = io_tx_valid && io_tx_ready;
    assign tx_pop  = io_net_out_valid && io_net_out_ready;

    // Occupancy FSM with registered ready/valid derived from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state         <= TX_EMPTY;
            io_tx_ready      <= 1'b0;
            io_net_out_valid <= 1'b0;
        end else begin
            case (tx_state)
                TX_EMPTY: begin
                    io_tx_ready <= 1'b1;
                    if (tx_push) begin
                        tx_state         <= TX_ONE;
                        io_net_out_valid <= 1'b1;
                    end
                end
                TX_ONE: begin
                    if (tx_push && !tx_pop) begin
                        tx_state    <= TX_TWO;
                        io_tx_ready <= 1'b0;
                    end else if (!tx_push && tx_pop) begin
                        tx_state         <= TX_EMPTY;
                        io_net_out_valid <= 1'b0;
                    end
                end
                TX_TWO: begin
                    if (tx_pop) begin
                        tx_state    <= TX_ONE;
                        io_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    tx_state         <= TX_EMPTY;
                    io_tx_ready      <= 1'b1;
                    io_net_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Entry storage; head always holds the oldest message
    always_ff @(posedge clk) begin
        case (tx_state)
            TX_EMPTY: if (tx_push) head <= tx_in;
            TX_ONE: begin
                if (tx_push && tx_pop) head <= tx_in;
                else if (tx_push)      tail <= tx_in;
            end
            TX_TWO:   if (tx_pop) head <= tail;
            default:  ;
        endcase
    end

    assign io_net_out_bits_header_src         = MY_ID;
    assign io_net_out_bits_header_dst         = head.dst;
    assign io_net_out_bits_payload_addr_block = head.addr_block;
    assign io_net_out_bits_payload_p_type     = head.p_type;

endmodule
`default_nettype wire

// File: tb/tb_coreriscv_axi4_network_endpoint.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coreriscv_axi4_network_endpoint
//  Description : Self-checking bench for the network endpoint (PORT_ID=1,
//                RX_DEPTH=4): directed receive vectors, back-pressure, misroute
//                clear, transmit stall, reset flush and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coreriscv_axi4_network_endpoint;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_net_in_valid;
    logic        io_net_in_ready;
    logic [1:0]  io_net_in_bits_header_src;
    logic [1:0]  io_net_in_bits_header_dst;
    logic [25:0] io_net_in_bits_payload_addr_block;
    logic [1:0]  io_net_in_bits_payload_p_type;
    logic        io_rx_valid;
    logic        io_rx_ready;
    logic [1:0]  io_rx_bits_src;
    logic [25:0] io_rx_bits_addr_block;
    logic [1:0]  io_rx_bits_p_type;
    logic        io_tx_valid;
    logic        io_tx_ready;
    logic [1:0]  io_tx_bits_dst;
    logic [25:0] io_tx_bits_addr_block;
    logic [1:0]  io_tx_bits_p_type;
    logic        io_net_out_valid;
    logic        io_net_out_ready;
    logic [1:0]  io_net_out_bits_header_src;
    logic [1:0]  io_net_out_bits_header_dst;
    logic [25:0] io_net_out_bits_payload_addr_block;
    logic [1:0]  io_net_out_bits_payload_p_type;
    logic        io_misroute;
    logic        io_misroute_clr;

    coreriscv_axi4_network_endpoint #(
        .PORT_ID  (1),
        .RX_DEPTH (4)
    ) dut (
        .clk                                (clk),
        .reset                              (reset),
        .io_net_in_valid                    (io_net_in_valid),
        .io_net_in_ready                    (io_net_in_ready),
        .io_net_in_bits_header_src          (io_net_in_bits_header_src),
        .io_net_in_bits_header_dst          (io_net_in_bits_header_dst),
        .io_net_in_bits_payload_addr_block  (io_net_in_bits_payload_addr_block),
        .io_net_in_bits_payload_p_type      (io_net_in_bits_payload_p_type),
        .io_rx_valid                        (io_rx_valid),
        .io_rx_ready                        (io_rx_ready),
        .io_rx_bits_src                     (io_rx_bits_src),
        .io_rx_bits_addr_block              (io_rx_bits_addr_block),
        .io_rx_bits_p_type                  (io_rx_bits_p_type),
        .io_tx_valid                        (io_tx_valid),
        .io_tx_ready                        (io_tx_ready),
        .io_tx_bits_dst                     (io_tx_bits_dst),
        .io_tx_bits_addr_block              (io_tx_bits_addr_block),
        .io_tx_bits_p_type                  (io_tx_bits_p_type),
        .io_net_out_valid                   (io_net_out_valid),
        .io_net_out_ready                   (io_net_out_ready),
        .io_net_out_bits_header_src         (io_net_out_bits_header_src),
        .io_net_out_bits_header_dst         (io_net_out_bits_header_dst),
        .io_net_out_bits_payload_addr_block (io_net_out_bits_payload_addr_block),
        .io_net_out_bits_payload_p_type     (io_net_out_bits_payload_p_type),
        .io_misroute                        (io_misroute),
        .io_misroute_clr                    (io_misroute_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dst;
        logic [1:0]  src;
        logic [25:0] addr;
        logic [1:0]  ptype;
        logic        exp_rx;
        logic        exp_mis;
    } rx_vec_t;

    rx_vec_t     vecs [6];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [29:0] rxq [$];
    logic [31:0] txq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_in(input logic [1:0] dst, input logic [1:0] src,
                           input logic [25:0] addr, input logic [1:0] pt);
        io_net_in_valid                   = 1'b1;
        io_net_in_bits_header_dst         = dst;
        io_net_in_bits_header_src         = src;
        io_net_in_bits_payload_addr_block = addr;
        io_net_in_bits_payload_p_type     = pt;
    endtask

    task automatic send_tx(input logic [1:0] dst, input logic [25:0] addr, input logic [1:0] pt);
        io_tx_valid           = 1'b1;
        io_tx_bits_dst        = dst;
        io_tx_bits_addr_block = addr;
        io_tx_bits_p_type     = pt;
    endtask

    function automatic logic [31:0] out_word();
        return {io_net_out_bits_header_src, io_net_out_bits_header_dst,
                io_net_out_bits_payload_addr_block, io_net_out_bits_payload_p_type};
    endfunction

    function automatic logic [29:0] rx_word();
        return {io_rx_bits_src, io_rx_bits_addr_block, io_rx_bits_p_type};
    endfunction

    // Scoreboard bookkeeping for the transfers that will happen at the next edge
    task automatic account(input string tag);
        logic [29:0] er;
        logic [31:0] et;
        if (io_rx_valid && io_rx_ready) begin
            if (rxq.size() == 0) check({tag, "_rx_extra"}, 64'(rx_word()), 64'hDEAD);
            else begin
                er = rxq.pop_front();
                check({tag, "_rx_data"}, 64'(rx_word()), 64'(er));
            end
        end
        if (io_net_in_valid && io_net_in_ready && io_net_in_bits_header_dst == 2'd1)
            rxq.push_back({io_net_in_bits_header_src, io_net_in_bits_payload_addr_block,
                           io_net_in_bits_payload_p_type});
        if (io_net_out_valid && io_net_out_ready) begin
            if (txq.size() == 0) check({tag, "_tx_extra"}, 64'(out_word()), 64'hDEAD);
            else begin
                et = txq.pop_front();
                check({tag, "_tx_data"}, 64'(out_word()), 64'(et));
            end
        end
        if (io_tx_valid && io_tx_ready)
            txq.push_back({2'd1, io_tx_bits_dst, io_tx_bits_addr_block, io_tx_bits_p_type});
    endtask

    initial begin
        vecs[0] = '{2'd1, 2'd2, 26'h0ABCDEF, 2'd3, 1'b1, 1'b0};
        vecs[1] = '{2'd3, 2'd0, 26'h1234567, 2'd1, 1'b0, 1'b1};
        vecs[2] = '{2'd1, 2'd0, 26'h3FFFFFF, 2'd0, 1'b1, 1'b0};
        vecs[3] = '{2'd0, 2'd3, 26'h0000001, 2'd2, 1'b0, 1'b1};
        vecs[4] = '{2'd2, 2'd1, 26'h2AAAAAA, 2'd1, 1'b0, 1'b1};
        vecs[5] = '{2'd1, 2'd3, 26'h0000000, 2'd2, 1'b1, 1'b0};

        reset = 1'b0;
        io_net_in_valid = 1'b0;
        io_net_in_bits_header_src = '0;
        io_net_in_bits_header_dst = '0;
        io_net_in_bits_payload_addr_block = '0;
        io_net_in_bits_payload_p_type = '0;
        io_rx_ready = 1'b0;
        io_tx_valid = 1'b0;
        io_tx_bits_dst = '0;
        io_tx_bits_addr_block = '0;
        io_tx_bits_p_type = '0;
        io_net_out_ready = 1'b0;
        io_misroute_clr = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_in_ready",  64'(io_net_in_ready),  64'd0);
        check("rst_rx_valid",  64'(io_rx_valid),      64'd0);
        check("rst_tx_ready",  64'(io_tx_ready),      64'd0);
        check("rst_out_valid", 64'(io_net_out_valid), 64'd0);
        check("rst_misroute",  64'(io_misroute),      64'd0);
        reset = 1'b1;
        tick();
        check("rel_in_ready",  64'(io_net_in_ready),  64'd1);
        check("rel_tx_ready",  64'(io_tx_ready),      64'd1);
        check("rel_rx_valid",  64'(io_rx_valid),      64'd0);

        // Directed receive vectors: accept/filter, then drain and clear
        for (int i = 0; i < 6; i++) begin
            send_in(vecs[i].dst, vecs[i].src, vecs[i].addr, vecs[i].ptype);
            tick();
            io_net_in_valid = 1'b0;
            check($sformatf("vec%0d_rx_valid", i), 64'(io_rx_valid), 64'(vecs[i].exp_rx));
            check($sformatf("vec%0d_misroute", i), 64'(io_misroute), 64'(vecs[i].exp_mis));
            if (vecs[i].exp_rx)
                check($sformatf("vec%0d_rx_bits", i), 64'(rx_word()),
                      64'({vecs[i].src, vecs[i].addr, vecs[i].ptype}));
            io_rx_ready = 1'b1;
            io_misroute_clr = 1'b1;
            tick();
            io_rx_ready = 1'b0;
            io_misroute_clr = 1'b0;
            check($sformatf("vec%0d_drained", i), 64'(io_rx_valid), 64'd0);
            check($sformatf("vec%0d_cleared", i), 64'(io_misroute), 64'd0);
        end

        // Fill to full with rx_ready low
        for (int c = 0; c < 4; c++) begin
            send_in(2'd1, 2'(c), 26'h100 + 26'(c), 2'(c));
            check($sformatf("fill%0d_ready", c), 64'(io_net_in_ready), 64'd1);
            tick();
        end
        send_in(2'd1, 2'd0, 26'h104, 2'd0);
        check("full_ready", 64'(io_net_in_ready), 64'd0);
        check("full_head", 64'(io_rx_bits_addr_block), 64'h100);
        tick();
        check("full_ready_hold", 64'(io_net_in_ready), 64'd0);
        check("full_head_stable", 64'(io_rx_bits_addr_block), 64'h100);
        send_in(2'd3, 2'd0, 26'h999, 2'd0);
        tick();
        check("full_no_misroute", 64'(io_misroute), 64'd0);
        send_in(2'd1, 2'd0, 26'h104, 2'd0);
        io_rx_ready = 1'b1;
        check("pop_cycle_ready", 64'(io_net_in_ready), 64'd0);
        tick();
        io_rx_ready = 1'b0;
        check("after_pop_ready", 64'(io_net_in_ready), 64'd1);
        check("after_pop_head", 64'(io_rx_bits_addr_block), 64'h101);
        tick();
        io_net_in_valid = 1'b0;
        check("refull_ready", 64'(io_net_in_ready), 64'd0);
        io_rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d_valid", k), 64'(io_rx_valid), 64'd1);
            check($sformatf("drain%0d_addr", k), 64'(io_rx_bits_addr_block), 64'h101 + 64'(k));
            tick();
        end
        io_rx_ready = 1'b0;
        check("drain_empty", 64'(io_rx_valid), 64'd0);
        check("drain_ready", 64'(io_net_in_ready), 64'd1);

        // Misroute clear priority
        send_in(2'd3, 2'd0, 26'h5, 2'd0);
        io_misroute_clr = 1'b1;
        tick();
        io_net_in_valid = 1'b0;
        io_misroute_clr = 1'b0;
        check("mis_set_over_clr", 64'(io_misroute), 64'd1);
        check("mis_no_rx", 64'(io_rx_valid), 64'd0);
        io_misroute_clr = 1'b1;
        tick();
        io_misroute_clr = 1'b0;
        check("mis_clr", 64'(io_misroute), 64'd0);
        send_in(2'd3, 2'd0, 26'h6, 2'd0);
        tick();
        check("mis_set", 64'(io_misroute), 64'd1);
        send_in(2'd2, 2'd0, 26'h7, 2'd0);
        io_misroute_clr = 1'b1;
        tick();
        io_net_in_valid = 1'b0;
        io_misroute_clr = 1'b0;
        check("mis_coincident", 64'(io_misroute), 64'd1);
        io_misroute_clr = 1'b1;
        tick();
        io_misroute_clr = 1'b0;
        check("mis_clr2", 64'(io_misroute), 64'd0);

        // Transmit stall and ordered release (third entry is loopback)
        send_tx(2'd2, 26'hA, 2'd1);
        tick();
        check("tx_one_valid", 64'(io_net_out_valid), 64'd1);
        check("tx_one_ready", 64'(io_tx_ready), 64'd1);
        check("tx_one_bits", 64'(out_word()), 64'({2'd1, 2'd2, 26'hA, 2'd1}));
        send_tx(2'd0, 26'hB, 2'd2);
        tick();
        check("tx_two_ready", 64'(io_tx_ready), 64'd0);
        send_tx(2'd1, 26'hC, 2'd3);
        tick();
        check("tx_stall_ready", 64'(io_tx_ready), 64'd0);
        check("tx_stall_head", 64'(out_word()), 64'({2'd1, 2'd2, 26'hA, 2'd1}));
        io_net_out_ready = 1'b1;
        tick();
        check("tx_pop1_ready", 64'(io_tx_ready), 64'd1);
        check("tx_pop1_bits", 64'(out_word()), 64'({2'd1, 2'd0, 26'hB, 2'd2}));
        tick();
        io_tx_valid = 1'b0;
        check("tx_pop2_valid", 64'(io_net_out_valid), 64'd1);
        check("tx_loopback_bits", 64'(out_word()), 64'({2'd1, 2'd1, 26'hC, 2'd3}));
        tick();
        io_net_out_ready = 1'b0;
        check("tx_empty", 64'(io_net_out_valid), 64'd0);

        // Reset with queued traffic on both paths
        for (int c = 0; c < 3; c++) begin
            send_in(2'd1, 2'd2, 26'h200 + 26'(c), 2'd1);
            tick();
        end
        io_net_in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            send_tx(2'd3, 26'h300 + 26'(c), 2'd2);
            tick();
        end
        io_tx_valid = 1'b0;
        check("pre_rst_rx_valid", 64'(io_rx_valid), 64'd1);
        check("pre_rst_out_valid", 64'(io_net_out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_rx_valid", 64'(io_rx_valid), 64'd0);
        check("async_rst_out_valid", 64'(io_net_out_valid), 64'd0);
        check("async_rst_in_ready", 64'(io_net_in_ready), 64'd0);
        check("async_rst_tx_ready", 64'(io_tx_ready), 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        io_rx_ready = 1'b1;
        io_net_out_ready = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(io_net_in_ready), 64'd1);
        check("post_rst_tx_ready", 64'(io_tx_ready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("post_rst_rx_stale%0d", c), 64'(io_rx_valid), 64'd0);
            check($sformatf("post_rst_tx_stale%0d", c), 64'(io_net_out_valid), 64'd0);
            tick();
        end

        // Random concurrent traffic against a scoreboard
        for (int cyc = 0; cyc < 10000; cyc++) begin
            io_net_in_valid = ($urandom_range(0, 3) != 0);
            io_net_in_bits_header_dst = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd1;
            io_net_in_bits_header_src = 2'($urandom);
            io_net_in_bits_payload_addr_block = 26'($urandom);
            io_net_in_bits_payload_p_type = 2'($urandom);
            io_rx_ready = ($urandom_range(0, 2) != 0);
            io_tx_valid = ($urandom_range(0, 1) != 0);
            io_tx_bits_dst = 2'($urandom);
            io_tx_bits_addr_block = 26'($urandom);
            io_tx_bits_p_type = 2'($urandom);
            io_net_out_ready = ($urandom_range(0, 2) != 0);
            account("rand");
            tick();
        end
        io_net_in_valid = 1'b0;
        io_tx_valid = 1'b0;
        io_rx_ready = 1'b1;
        io_net_out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            account("flush");
            tick();
        end
        check("sb_rx_left", 64'(rxq.size()), 64'd0);
        check("sb_tx_left", 64'(txq.size()), 64'd0);
        check("sb_rx_valid", 64'(io_rx_valid), 64'd0);
        check("sb_out_valid", 64'(io_net_out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coreriscv_axi4_network_endpoint.md
CORERISCV_AXI4_NETWORK_ENDPOINT -- requirements
Module: coreriscv_axi4_network_endpoint

Interface
REQ-001 The block SHALL have parameter PORT_ID, default 0, giving the 2-bit network address of this endpoint.
REQ-002 The block SHALL have parameter RX_DEPTH, default 4, giving receive-queue depth; legal values are 2, 4 and 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous active-low reset; 0 resets the block.
REQ-005 The block SHALL have port io_net_in_valid, input, 1 bit: a bus-side delivered message is valid.
REQ-006 The block SHALL have port io_net_in_ready, output, 1 bit: the endpoint accepts the delivered message.
REQ-007 The block SHALL have ports io_net_in_bits_header_src/_dst (input, 2 each), _payload_addr_block (input, 26) and _payload_p_type (input, 2).
REQ-008 The block SHALL have ports io_rx_valid (output, 1), io_rx_ready (input, 1), io_rx_bits_src (output, 2), io_rx_bits_addr_block (output, 26) and io_rx_bits_p_type (output, 2): the client receive stream.
REQ-009 The block SHALL have ports io_tx_valid (input, 1), io_tx_ready (output, 1), io_tx_bits_dst (input, 2), io_tx_bits_addr_block (input, 26) and io_tx_bits_p_type (input, 2): the client transmit stream.
REQ-010 The block SHALL have ports io_net_out_valid (output, 1), io_net_out_ready (input, 1), io_net_out_bits_header_src/_dst (output, 2 each), _payload_addr_block (output, 26) and _payload_p_type (output, 2): the bus-side injection stream.
REQ-011 The block SHALL have port io_misroute (output, 1): sticky flag, set when a message with the wrong destination arrives.
REQ-012 The block SHALL have port io_misroute_clr (input, 1): synchronous clear for io_misroute.

Function
REQ-013 A transfer SHALL occur on any valid/ready pair when both are 1 at a rising clk edge; valid SHALL NOT depend combinationally on ready.
REQ-014 The receive path SHALL be a FIFO of RX_DEPTH entries holding {src, addr_block, p_type}, with io_net_in_ready = !full.
REQ-015 An accepted message with header_dst == PORT_ID SHALL be enqueued; io_rx_valid SHALL rise the cycle after enqueue (latency 1); there is no fall-through.
REQ-016 An accepted message with header_dst != PORT_ID SHALL be consumed without enqueue and SHALL set io_misroute the next cycle.
REQ-017 io_misroute_clr SHALL clear the flag, except a same-cycle misroute, which SHALL win and leave it set.
REQ-018 When the FIFO is full, io_net_in_ready SHALL be 0 for all messages, including misrouted ones.
REQ-019 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged; when full, a dequeue SHALL NOT re-open io_net_in_ready in the same cycle.
REQ-020 Read/write pointers SHALL be log2(RX_DEPTH) bits and wrap modulo RX_DEPTH, with a separate count of log2(RX_DEPTH)+1 bits.
REQ-021 io_rx_bits SHALL hold stable while io_rx_valid=1 and io_rx_ready=0.
REQ-022 The transmit path SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-023 Transmit transitions: EMPTY->ONE on tx push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; TWO->ONE on pop; all other cases hold state.
REQ-024 io_tx_ready SHALL be 1 in EMPTY and ONE and 0 in TWO (registered).
REQ-025 io_net_out_valid SHALL be 1 in ONE and TWO; outputs SHALL present the oldest entry with header_src = PORT_ID and header_dst = io_tx_bits_dst as captured.
REQ-026 A message with dst == PORT_ID (loopback) SHALL be sent unchanged; the bus returns it.
REQ-027 Receive and transmit paths SHALL be fully independent, with no ordering between them.

Reset
REQ-028 While reset=0 the block SHALL asynchronously force: FIFO empty, transmit state EMPTY, io_net_in_ready=0, io_rx_valid=0, io_tx_ready=0, io_net_out_valid=0 and io_misroute=0.
REQ-029 On the first clk edge after release, the block SHALL set io_net_in_ready=1 and io_tx_ready=1; data registers need no reset.
REQ-030 Reset asserted mid-transfer SHALL discard all queued messages with no partial output.

Structure
REQ-031 Field widths (src/dst 2, addr_block 26, p_type 2) and transmit state encodings SHALL live in the shared CoreRISCV_AXI4 package.
REQ-032 The receive FIFO SHALL be one sub-module, coreriscv_axi4_endpoint_queue, parameterised by depth and width (30).

Verification
REQ-033 PORT_ID=1: send dst=1, src=2, addr=0x0ABCDEF, p_type=3 -> next cycle io_rx_valid=1 with src=2, addr=0x0ABCDEF, p_type=3.
REQ-034 io_rx_ready=0: send 5 messages with dst=1 -> 4 accepted, then io_net_in_ready=0; one pop -> ready=1 the following cycle, order preserved.
REQ-035 Send dst=3 to PORT_ID=1 -> no rx_valid and io_misroute=1; pulse clr -> 0; clr coincident with another misroute -> stays 1.
REQ-036 io_net_out_ready=0: push 3 tx messages -> third stalls (tx_ready=0); release -> outputs in order with header_src=1.
REQ-037 Assert reset with 3 queued rx and 2 tx entries -> all valids 0 immediately; after release, no stale message appears.
REQ-038 Random concurrent rx/tx traffic over 10k cycles -> scoreboard shows no loss, duplication or reordering.
